// File: rtl/mem_responder_if.sv
// Word-wide data port between the core's memory-access unit and mem_responder.
// The core drives the request side; the responder returns registered read data.
interface mem_responder_if;
  logic        re;
  logic [3:0]  we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output re, we, addr, wdata,
    input  rdata
  );

  modport slave (
    input  re, we, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: target-side responder for the core's data port.
// Low half of the word address space is byte-writable on-chip RAM with a
// one-cycle registered read; high half is an I/O page holding a GPIO output
// register, a 64-bit free-running cycle counter (with a coherent HI shadow)
// and a byte-wide TX FIFO drained over a valid/ready stream.
// Optional build macro: MEM_RESP_GPIO_IN_EN adds a synchronised gpio_in
// input readable at I/O word offset 5.
module mem_responder #(
  parameter int RAM_WORDS = 1024,
  parameter int TX_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_responder_if.slave        bus,
  output logic [31:0]           gpio_out,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
`ifdef MEM_RESP_GPIO_IN_EN
  ,
  input  logic [31:0]           gpio_in
`endif
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int TX_AW  = $clog2(TX_DEPTH);
  localparam int TX_CW  = TX_AW + 1;

  localparam logic [2:0] OFF_GPIO  = 3'd0;
  localparam logic [2:0] OFF_CLO   = 3'd1;
  localparam logic [2:0] OFF_CHI   = 3'd2;
  localparam logic [2:0] OFF_TXD   = 3'd3;
  localparam logic [2:0] OFF_TXS   = 3'd4;
`ifdef MEM_RESP_GPIO_IN_EN
  localparam logic [2:0] OFF_GPIN  = 3'd5;
`endif

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic              io_sel;
  logic [2:0]        io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_re;
  logic [3:0]        ram_we;
  logic              io_wr_ok;

  assign io_sel   = bus.addr[29];
  assign io_off   = bus.addr[2:0];
  assign ram_idx  = bus.addr[RAM_AW-1:0];
  assign ram_re   = bus.re && !io_sel;
  // RAM writes are deliberately not gated by reset: a write issued in the
  // reset cycle still lands, only I/O side effects are suppressed.
  assign ram_we   = io_sel ? 4'b0000 : bus.we;
  assign io_wr_ok = io_sel && !reset;

  // Upper address bits that alias in both halves of the map.
  logic unused_addr;
  assign unused_addr = &{1'b0, bus.addr[28:RAM_AW]};

  // ---------------------------------------------------------------------
  // RAM: one byte-wide array per lane so each lane maps onto its own
  // block RAM with an independent write enable. Read-before-write falls
  // out of the non-blocking update.
  // ---------------------------------------------------------------------
  logic [31:0] ram_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [RAM_WORDS];
      logic [7:0] lane_q_reg;

      // Byte-lane write and registered read (old data on same-address write)
      always_ff @(posedge clk) begin
        if (ram_we[gi]) begin
          lane_mem[ram_idx] <= bus.wdata[8*gi +: 8];
        end
        if (ram_re) begin
          lane_q_reg <= lane_mem[ram_idx];
        end
      end

      assign ram_q[8*gi +: 8] = lane_q_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // I/O registers
  // ---------------------------------------------------------------------
  logic [31:0] gpio_reg;
  logic [63:0] cnt_reg;
  logic [31:0] shadow_reg;

  // GPIO output register with per-byte write enables
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_reg <= '0;
    end else if (io_wr_ok && io_off == OFF_GPIO) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.we[i]) begin
          gpio_reg[8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  assign gpio_out = gpio_reg;

  // Free-running 64-bit cycle counter; zero in the first cycle after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 64'd1;
    end
  end

  // Capture the upper counter half when the lower half is read so that a
  // later CYCLE_HI read pairs with it even if a carry happened in between
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg <= '0;
    end else if (bus.re && io_sel && io_off == OFF_CLO) begin
      shadow_reg <= cnt_reg[63:32];
    end
  end

`ifdef MEM_RESP_GPIO_IN_EN
  logic [31:0] gpio_meta_reg;
  logic [31:0] gpio_sync_reg;

  // Two-flop synchroniser for the asynchronous GPIO inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_meta_reg <= '0;
      gpio_sync_reg <= '0;
    end else begin
      gpio_meta_reg <= gpio_in;
      gpio_sync_reg <= gpio_meta_reg;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       fifo_mem [TX_DEPTH];
  logic [TX_AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [TX_AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [TX_CW-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             full;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             stat_clr;

  assign full     = (count_reg == TX_CW'(TX_DEPTH));
  assign tx_valid = (count_reg != '0);
  assign tx_data  = fifo_mem[rd_ptr_reg];

  // FIFO next-state: a full FIFO still accepts a push when it pops that cycle
  always_comb begin
    push_req    = io_wr_ok && io_off == OFF_TXD && bus.we[0];
    stat_clr    = io_wr_ok && io_off == OFF_TXS && bus.we[0];
    pop         = tx_valid && tx_ready;
    push_ok     = push_req && (!full || pop);
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;

    if (pop) begin
      rd_ptr_next = rd_ptr_reg + TX_AW'(1);
    end
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + TX_AW'(1);
    end
    if (push_ok && !pop) begin
      count_next = count_reg + TX_CW'(1);
    end else if (pop && !push_ok) begin
      count_next = count_reg - TX_CW'(1);
    end

    if (stat_clr) begin
      ovf_next = 1'b0;
    end else if (push_req && full && !pop) begin
      ovf_next = 1'b1;
    end
  end

  // FIFO pointer/count/overflow state; reset flushes queued bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

  // FIFO storage (not reset; validity is tracked by count)
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= bus.wdata[7:0];
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [3:0]  stat_count;
  logic [31:0] io_rdata;
  logic [31:0] io_q_reg;
  logic        sel_io_reg;

  assign stat_count = 4'(count_reg);

  // I/O page read multiplexer
  always_comb begin
    io_rdata = '0;
    case (io_off)
      OFF_GPIO: io_rdata = gpio_reg;
      OFF_CLO:  io_rdata = cnt_reg[31:0];
      OFF_CHI:  io_rdata = shadow_reg;
      OFF_TXS:  io_rdata = {23'b0, ovf_reg, full, 3'b0, stat_count};
`ifdef MEM_RESP_GPIO_IN_EN
      OFF_GPIN: io_rdata = gpio_sync_reg;
`endif
      default:  io_rdata = '0;
    endcase
  end

  // Registered read source select and I/O read data; both hold when re=0,
  // and reset points the output at a zeroed I/O register
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_io_reg <= 1'b1;
      io_q_reg   <= '0;
    end else if (bus.re) begin
      sel_io_reg <= io_sel;
      if (io_sel) begin
        io_q_reg <= io_rdata;
      end
    end
  end

  assign bus.rdata = sel_io_reg ? io_q_reg : ram_q;

endmodule
